// File: rtl/chess_pkg.sv
// Shared chess encodings: piece codes, colours, FSM states, start rank.
// Imported by the move sequencer and its geometry checker.
package chess_pkg;

  typedef logic [4:0] piece_t;

  localparam logic [2:0] T_PAWN   = 3'b001;
  localparam logic [2:0] T_KNIGHT = 3'b010;
  localparam logic [2:0] T_BISHOP = 3'b011;
  localparam logic [2:0] T_ROOK   = 3'b100;
  localparam logic [2:0] T_QUEEN  = 3'b101;
  localparam logic [2:0] T_KING   = 3'b110;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  localparam piece_t EMPTY = 5'b00000;

  typedef enum logic [2:0] {
    IDLE,
    HELD,
    CHECK,
    WALK,
    COMMIT,
    REJECT
  } state_t;

  localparam logic [2:0] BACK_RANK [8] = '{
    T_ROOK, T_KNIGHT, T_BISHOP, T_QUEEN,
    T_KING, T_BISHOP, T_KNIGHT, T_ROOK
  };

  // Piece found on square (r,c) of the opening position.
  function automatic piece_t start_piece(
    input int r,
    input int c,
    input int rows
  );
    piece_t p;
    p = EMPTY;
    if (c < 8) begin
      if (r == 0)
        p = {BACK_RANK[c], BLACK, 1'b1};
      else if (r == 1)
        p = {T_PAWN, BLACK, 1'b1};
      else if (r == rows - 2)
        p = {T_PAWN, WHITE, 1'b1};
      else if (r == rows - 1)
        p = {BACK_RANK[c], WHITE, 1'b1};
    end
    return p;
  endfunction

endpackage

// File: rtl/move_sequencer_geometry.sv
// Combinational move-shape and capture check.
// Also yields the unit step vector for path walks.
module move_geometry
  import chess_pkg::*;
#(
  parameter int ROW_W       = 3,
  parameter int COL_W       = 3,
  parameter int DOUBLE_STEP = 1
) (
  input  piece_t           i_piece,
  input  logic             i_tgt_occ,
  input  logic             i_tgt_blk,
  input  logic [ROW_W-1:0] i_org_r,
  input  logic [COL_W-1:0] i_org_c,
  input  logic [ROW_W-1:0] i_tgt_r,
  input  logic [COL_W-1:0] i_tgt_c,
  output logic             o_legal,
  output logic             o_walk,
  output logic [1:0]       o_sr,
  output logic [1:0]       o_sc
);

  localparam int MW   = (ROW_W > COL_W) ? ROW_W : COL_W;
  localparam int ROWS = 2 ** ROW_W;

  logic [ROW_W:0]   w_dr;
  logic [COL_W:0]   w_dc;
  logic [ROW_W:0]   w_drm;
  logic [COL_W:0]   w_dcm;
  logic [MW-1:0]    w_ar;
  logic [MW-1:0]    w_ac;
  logic             w_rneg;
  logic             w_rpos;
  logic             w_cneg;
  logic             w_cpos;
  logic             w_own;
  logic             w_fwd;
  logic             w_start;
  logic             w_p1;
  logic             w_p2;
  logic             w_px;
  logic             w_kn;
  logic             w_kg;
  logic             w_bi;
  logic             w_rk;
  logic             w_far;

  assign w_dr = {1'b0, i_tgt_r} - {1'b0, i_org_r};
  assign w_dc = {1'b0, i_tgt_c} - {1'b0, i_org_c};

  assign w_drm = w_dr[ROW_W] ? -w_dr : w_dr;
  assign w_dcm = w_dc[COL_W] ? -w_dc : w_dc;
  assign w_ar  = MW'(w_drm[ROW_W-1:0]);
  assign w_ac  = MW'(w_dcm[COL_W-1:0]);

  assign w_rneg = w_dr[ROW_W];
  assign w_rpos = !w_dr[ROW_W] && (w_dr != '0);
  assign w_cneg = w_dc[COL_W];
  assign w_cpos = !w_dc[COL_W] && (w_dc != '0);

  assign w_own = i_tgt_occ && (i_tgt_blk == i_piece[1]);

  // White runs toward row 0, black toward the last row.
  assign w_fwd   = i_piece[1] ? w_rpos : w_rneg;
  assign w_start = i_piece[1]
                 ? (i_org_r == ROW_W'(1))
                 : (i_org_r == ROW_W'(ROWS - 2));

  assign w_p1 = w_fwd && (w_ar == MW'(1))
             && (w_ac == '0) && !i_tgt_occ;
  assign w_p2 = (DOUBLE_STEP != 0) && w_start && w_fwd
             && (w_ar == MW'(2)) && (w_ac == '0)
             && !i_tgt_occ;
  assign w_px = w_fwd && (w_ar == MW'(1))
             && (w_ac == MW'(1)) && i_tgt_occ;

  assign w_kn = ((w_ar == MW'(1)) && (w_ac == MW'(2)))
             || ((w_ar == MW'(2)) && (w_ac == MW'(1)));
  assign w_kg = (w_ar <= MW'(1)) && (w_ac <= MW'(1));
  assign w_bi = (w_ar == w_ac);
  assign w_rk = (w_ar == '0) || (w_ac == '0);
  assign w_far = (w_ar > MW'(1)) || (w_ac > MW'(1));

  assign o_sr = w_rneg ? 2'b11 : (w_rpos ? 2'b01 : 2'b00);
  assign o_sc = w_cneg ? 2'b11 : (w_cpos ? 2'b01 : 2'b00);

  // Shape decode per piece type, then mask own-colour captures.
  always_comb begin
    o_legal = 1'b0;
    o_walk  = 1'b0;
    case (i_piece[4:2])
      T_PAWN: begin
        o_legal = w_p1 || w_p2 || w_px;
        o_walk  = w_p2;
      end
      T_KNIGHT: o_legal = w_kn;
      T_BISHOP: begin
        o_legal = w_bi;
        o_walk  = w_far;
      end
      T_ROOK: begin
        o_legal = w_rk;
        o_walk  = w_far;
      end
      T_QUEEN: begin
        o_legal = w_bi || w_rk;
        o_walk  = w_far;
      end
      T_KING:  o_legal = w_kg;
      default: o_legal = 1'b0;
    endcase
    if (w_own || !i_piece[0])
      o_legal = 1'b0;
    o_walk = o_walk && o_legal;
  end

endmodule

// File: rtl/move_sequencer.sv
// Live board owner and select/place move FSM for one cursor.
// Checks shape, walks sliding paths, commits or rejects.
module move_sequencer
  import chess_pkg::*;
#(
  parameter int ROW_W        = 3,
  parameter int COL_W        = 3,
  parameter int ENFORCE_TURN = 1,
  parameter int DOUBLE_STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ROW_W-1:0] cur_row,
  input  logic [COL_W-1:0] cur_col,
  input  logic             select,
  input  logic             place,
  input  logic [ROW_W-1:0] rd_row,
  input  logic [COL_W-1:0] rd_col,
  output logic [4:0]       rd_piece,
  output logic             holding,
  output logic [ROW_W-1:0] held_row,
  output logic [COL_W-1:0] held_col,
  output logic             busy,
  output logic             turn,
  output logic             move_ok,
  output logic             move_err,
  output logic             game_over
);

  localparam int ROWS = 2 ** ROW_W;
  localparam int COLS = 2 ** COL_W;

  piece_t           r_board [ROWS][COLS];
  state_t           r_state;
  piece_t           r_piece;
  logic [ROW_W-1:0] r_org_r;
  logic [COL_W-1:0] r_org_c;
  logic [ROW_W-1:0] r_tgt_r;
  logic [COL_W-1:0] r_tgt_c;
  logic [ROW_W-1:0] r_wlk_r;
  logic [COL_W-1:0] r_wlk_c;
  logic             r_holding;
  logic             r_busy;
  logic             r_turn;
  logic             r_ok;
  logic             r_err;
  logic             r_over;
  piece_t           r_rd;

  piece_t           w_cur_pc;
  piece_t           w_tgt_pc;
  logic             w_wlk_occ;
  logic             w_legal;
  logic             w_walk;
  logic [1:0]       w_sr;
  logic [1:0]       w_sc;
  logic [ROW_W-1:0] w_sr_x;
  logic [COL_W-1:0] w_sc_x;
  logic [ROW_W-1:0] w_nxt_r;
  logic [COL_W-1:0] w_nxt_c;
  logic             w_own_turn;
  logic             w_on_org;

  assign w_cur_pc  = r_board[cur_row][cur_col];
  assign w_tgt_pc  = r_board[r_tgt_r][r_tgt_c];
  assign w_wlk_occ = r_board[r_wlk_r][r_wlk_c][0];

  assign w_sr_x  = {{(ROW_W-2){w_sr[1]}}, w_sr};
  assign w_sc_x  = {{(COL_W-2){w_sc[1]}}, w_sc};
  assign w_nxt_r = r_wlk_r + w_sr_x;
  assign w_nxt_c = r_wlk_c + w_sc_x;

  assign w_own_turn = (ENFORCE_TURN == 0)
                   || (w_cur_pc[1] == r_turn);
  assign w_on_org   = (cur_row == r_org_r)
                   && (cur_col == r_org_c);

  move_geometry #(
    .ROW_W       (ROW_W),
    .COL_W       (COL_W),
    .DOUBLE_STEP (DOUBLE_STEP)
  ) u_geom (
    .i_piece   (r_piece),
    .i_tgt_occ (w_tgt_pc[0]),
    .i_tgt_blk (w_tgt_pc[1]),
    .i_org_r   (r_org_r),
    .i_org_c   (r_org_c),
    .i_tgt_r   (r_tgt_r),
    .i_tgt_c   (r_tgt_c),
    .o_legal   (w_legal),
    .o_walk    (w_walk),
    .o_sr      (w_sr),
    .o_sc      (w_sc)
  );

  // Board storage: start layout on reset, two-square write on commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          r_board[r][c] <= start_piece(r, c, ROWS);
    end else if (r_state == COMMIT) begin
      r_board[r_tgt_r][r_tgt_c] <= r_piece;
      r_board[r_org_r][r_org_c] <= EMPTY;
    end
  end

  // Display read port, one cycle behind the address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_rd <= EMPTY;
    else
      r_rd <= r_board[rd_row][rd_col];
  end

  // Move FSM with registered status and pulse outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_piece   <= EMPTY;
      r_org_r   <= '0;
      r_org_c   <= '0;
      r_tgt_r   <= '0;
      r_tgt_c   <= '0;
      r_wlk_r   <= '0;
      r_wlk_c   <= '0;
      r_holding <= 1'b0;
      r_busy    <= 1'b0;
      r_turn    <= 1'b0;
      r_ok      <= 1'b0;
      r_err     <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_ok  <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (select) begin
            if (!r_over && w_cur_pc[0] && w_own_turn) begin
              r_piece   <= w_cur_pc;
              r_org_r   <= cur_row;
              r_org_c   <= cur_col;
              r_holding <= 1'b1;
              r_state   <= HELD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        HELD: begin
          if (place) begin
            r_holding <= 1'b0;
            if (w_on_org) begin
              r_state <= IDLE;
            end else begin
              r_tgt_r <= cur_row;
              r_tgt_c <= cur_col;
              r_busy  <= 1'b1;
              r_state <= CHECK;
            end
          end else if (select && w_cur_pc[0]
                       && (w_cur_pc[1] == r_piece[1])) begin
            r_piece <= w_cur_pc;
            r_org_r <= cur_row;
            r_org_c <= cur_col;
          end
        end
        CHECK: begin
          if (!w_legal) begin
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            r_state <= REJECT;
          end else if (w_walk) begin
            r_wlk_r <= r_org_r + w_sr_x;
            r_wlk_c <= r_org_c + w_sc_x;
            r_state <= WALK;
          end else begin
            r_busy  <= 1'b0;
            r_ok    <= 1'b1;
            r_state <= COMMIT;
          end
        end
        WALK: begin
          if (w_wlk_occ) begin
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            r_state <= REJECT;
          end else if ((w_nxt_r == r_tgt_r)
                       && (w_nxt_c == r_tgt_c)) begin
            r_busy  <= 1'b0;
            r_ok    <= 1'b1;
            r_state <= COMMIT;
          end else begin
            r_wlk_r <= w_nxt_r;
            r_wlk_c <= w_nxt_c;
          end
        end
        COMMIT: begin
          if (ENFORCE_TURN != 0)
            r_turn <= ~r_turn;
          if (w_tgt_pc[0] && (w_tgt_pc[4:2] == T_KING))
            r_over <= 1'b1;
          r_state <= IDLE;
        end
        REJECT: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rd_piece  = r_rd;
  assign holding   = r_holding;
  assign held_row  = r_org_r;
  assign held_col  = r_org_c;
  assign busy      = r_busy;
  assign turn      = r_turn;
  assign move_ok   = r_ok;
  assign move_err  = r_err;
  assign game_over = r_over;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer.
// Hand-computed expectations checked with immediate assertions.
module tb_move_sequencer;

  logic       clk;
  logic       reset;
  logic [2:0] cur_row;
  logic [2:0] cur_col;
  logic       select;
  logic       place;
  logic [2:0] rd_row;
  logic [2:0] rd_col;
  logic [4:0] rd_piece;
  logic       holding;
  logic [2:0] held_row;
  logic [2:0] held_col;
  logic       busy;
  logic       turn;
  logic       move_ok;
  logic       move_err;
  logic       game_over;

  logic [4:0] rd_piece2;
  logic       holding2;
  logic [2:0] held_row2;
  logic [2:0] held_col2;
  logic       busy2;
  logic       turn2;
  logic       move_ok2;
  logic       move_err2;
  logic       game_over2;

  int errors = 0;
  int checks = 0;
  logic [4:0] pc;

  move_sequencer #(
    .ROW_W(3), .COL_W(3),
    .ENFORCE_TURN(1), .DOUBLE_STEP(1)
  ) u_dut (
    .clk(clk), .reset(reset),
    .cur_row(cur_row), .cur_col(cur_col),
    .select(select), .place(place),
    .rd_row(rd_row), .rd_col(rd_col),
    .rd_piece(rd_piece), .holding(holding),
    .held_row(held_row), .held_col(held_col),
    .busy(busy), .turn(turn),
    .move_ok(move_ok), .move_err(move_err),
    .game_over(game_over)
  );

  move_sequencer #(
    .ROW_W(3), .COL_W(3),
    .ENFORCE_TURN(0), .DOUBLE_STEP(1)
  ) u_dut_free (
    .clk(clk), .reset(reset),
    .cur_row(cur_row), .cur_col(cur_col),
    .select(select), .place(place),
    .rd_row(rd_row), .rd_col(rd_col),
    .rd_piece(rd_piece2), .holding(holding2),
    .held_row(held_row2), .held_col(held_col2),
    .busy(busy2), .turn(turn2),
    .move_ok(move_ok2), .move_err(move_err2),
    .game_over(game_over2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic sel(input int r, input int c);
    @(negedge clk);
    cur_row = 3'(r);
    cur_col = 3'(c);
    select  = 1'b1;
    @(negedge clk);
    select  = 1'b0;
  endtask

  task automatic plc(input int r, input int c);
    @(negedge clk);
    cur_row = 3'(r);
    cur_col = 3'(c);
    place   = 1'b1;
    @(negedge clk);
    place   = 1'b0;
  endtask

  task automatic both(input int r, input int c);
    @(negedge clk);
    cur_row = 3'(r);
    cur_col = 3'(c);
    select  = 1'b1;
    place   = 1'b1;
    @(negedge clk);
    select  = 1'b0;
    place   = 1'b0;
  endtask

  task automatic rd(input int r, input int c,
                    output logic [4:0] p);
    @(negedge clk);
    rd_row = 3'(r);
    rd_col = 3'(c);
    @(negedge clk);
    p = rd_piece;
  endtask

  // Entered one cycle after the place pulse was sampled.
  task automatic wait_res(output int lat);
    lat = 1;
    while (!(move_ok || move_err) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic mv(input int fr, input int fc,
                    input int tr, input int tc,
                    input logic exp_ok, input int exp_lat,
                    input string tag);
    int lat;
    sel(fr, fc);
    plc(tr, tc);
    wait_res(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_ok"}, move_ok, exp_ok);
    chk({tag, "_err"}, move_err, !exp_ok);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    reset   = 1'b0;
    cur_row = '0;
    cur_col = '0;
    select  = 1'b0;
    place   = 1'b0;
    rd_row  = '0;
    rd_col  = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_holding", holding, 0);
    chk("rst_busy", busy, 0);
    chk("rst_turn", turn, 0);
    chk("rst_ok", move_ok, 0);
    chk("rst_err", move_err, 0);
    chk("rst_over", game_over, 0);
    chk("rst_rd", rd_piece, 0);
    reset = 1'b1;
    @(negedge clk);
    rd(0, 4, pc); chk("start_bk", pc, 5'h1B);
    rd(7, 3, pc); chk("start_wq", pc, 5'h15);
    rd(1, 6, pc); chk("start_bp", pc, 5'h07);
    rd(4, 4, pc); chk("start_empty", pc, 5'h00);

    // 1: e-pawn double step with one walk square
    sel(6, 4);
    chk("t1_hold", holding, 1);
    chk("t1_hrow", held_row, 6);
    chk("t1_hcol", held_col, 4);
    plc(4, 4);
    chk("t1_busy", busy, 1);
    chk("t1_hold0", holding, 0);
    wait_res(lat);
    chk("t1_lat", lat, 3);
    chk("t1_ok", move_ok, 1);
    @(negedge clk);
    chk("t1_okpulse", move_ok, 0);
    chk("t1_turn", turn, 1);
    chk("t1_busy0", busy, 0);
    rd(4, 4, pc); chk("t1_dst", pc, 5'h05);
    rd(6, 4, pc); chk("t1_src", pc, 5'h00);

    // 2: rook blocked by its own pawn
    do_reset();
    mv(7, 0, 5, 0, 1'b0, 3, "t2_rook");
    chk("t2_turn", turn, 0);
    rd(7, 0, pc); chk("t2_rook_stay", pc, 5'h11);
    rd(6, 0, pc); chk("t2_pawn_stay", pc, 5'h05);

    // 3: wrong-colour select; free-turn instance accepts it
    do_reset();
    sel(1, 0);
    chk("t3_err", move_err, 1);
    chk("t3_hold", holding, 0);
    chk("t3_free_hold", holding2, 1);
    chk("t3_free_err", move_err2, 0);

    // 4: knight tour ending on a vacated square
    do_reset();
    mv(7, 6, 5, 5, 1'b1, 2, "t4_wn1");
    mv(0, 1, 2, 2, 1'b1, 2, "t4_bn1");
    mv(5, 5, 3, 4, 1'b1, 2, "t4_wn2");
    mv(1, 3, 3, 3, 1'b1, 3, "t4_bp");
    mv(3, 4, 1, 3, 1'b1, 2, "t4_wn3");
    rd(1, 3, pc); chk("t4_dst", pc, 5'h09);
    chk("t4_turn", turn, 1);

    // 5: re-latch, cancel, place-wins, own capture
    do_reset();
    sel(6, 4);
    sel(6, 3);
    chk("t5_hcol", held_col, 3);
    chk("t5_hrow", held_row, 6);
    plc(6, 3);
    chk("t5_cancel_hold", holding, 0);
    chk("t5_cancel_ok", move_ok, 0);
    chk("t5_cancel_err", move_err, 0);
    @(negedge clk);
    chk("t5_cancel_ok2", move_ok, 0);
    chk("t5_cancel_err2", move_err, 0);
    sel(6, 4);
    sel(1, 4);
    chk("t5_enemy_ignored", held_row, 6);
    both(5, 4);
    wait_res(lat);
    chk("t5_both_lat", lat, 2);
    chk("t5_both_ok", move_ok, 1);
    @(negedge clk);
    rd(5, 4, pc); chk("t5_both_dst", pc, 5'h05);
    do_reset();
    mv(7, 1, 6, 3, 1'b0, 2, "t5_owncap");
    rd(7, 1, pc); chk("t5_owncap_src", pc, 5'h09);
    chk("t5_owncap_turn", turn, 0);

    // 6: reset during a walk, then a king capture
    do_reset();
    sel(6, 4);
    plc(4, 4);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_hold", holding, 0);
    chk("t6_rst_ok", move_ok, 0);
    @(negedge clk);
    reset = 1'b1;
    rd(6, 4, pc); chk("t6_restore_src", pc, 5'h05);
    rd(4, 4, pc); chk("t6_restore_dst", pc, 5'h00);
    chk("t6_restore_turn", turn, 0);
    mv(6, 4, 4, 4, 1'b1, 3, "t6_e4");
    mv(1, 5, 2, 5, 1'b1, 2, "t6_f6");
    mv(7, 3, 3, 7, 1'b1, 5, "t6_qh5");
    mv(1, 0, 2, 0, 1'b1, 2, "t6_a6");
    mv(3, 7, 0, 4, 1'b1, 4, "t6_qxk");
    chk("t6_over", game_over, 1);
    rd(0, 4, pc); chk("t6_qsq", pc, 5'h15);
    sel(1, 1);
    chk("t6_over_err1", move_err, 1);
    chk("t6_over_hold1", holding, 0);
    sel(6, 0);
    chk("t6_over_err2", move_err, 1);
    chk("t6_over_sticky", game_over, 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
